// File: rtl/image_sequencer.sv
// Button/auto driven image index sequencer; index changes commit only on a V_sync falling edge.
// Optional auto-advance is compiled in with `define IMG_SEQ_AUTO_EN.

module img_seq_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic init,
  input  logic raw,
  output logic rise
);
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic          level, level_q;
  logic [CW-1:0] cnt;

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge CLK or negedge init) begin
    if (!init) begin
      sync    <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync    <= {sync[0], raw};
      level_q <= level;
      if (sync[1] != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise = level & ~level_q;
endmodule

module image_sequencer #(
  parameter int NUM_IMAGES      = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int AUTO_FRAMES     = 180
) (
  input  logic       CLK,
  input  logic       init,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       auto_mode,
  input  logic       V_sync,
  output logic [2:0] num,
  output logic       pending
);
  localparam int NB = 2;

  typedef enum logic {IDLE, WAIT_FRAME} state_t;

  state_t          state;
  logic [2:0]      target, t_step;
  logic [NB-1:0]   btn_raw, btn_rise;
  logic [1:0]      vs_sync;
  logic            vs_prev, frame;
  logic            manual_req, auto_req, step_next, step_prev, accept;

  assign btn_raw = {btn_prev, btn_next};

  generate
    for (genvar b = 0; b < NB; b++) begin : g_btn
      img_seq_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .CLK  (CLK),
        .init (init),
        .raw  (btn_raw[b]),
        .rise (btn_rise[b])
      );
    end
  endgenerate

  always_ff @(posedge CLK or negedge init) begin
    if (!init) begin
      vs_sync <= '0;
      vs_prev <= 1'b0;
    end else begin
      vs_sync <= {vs_sync[0], V_sync};
      vs_prev <= vs_sync[1];
    end
  end

  assign frame      = ~vs_sync[1] & vs_prev;
  assign manual_req = |btn_rise;

`ifdef IMG_SEQ_AUTO_EN
  localparam int FW = (AUTO_FRAMES < 2) ? 1 : $clog2(AUTO_FRAMES + 1);

  logic [1:0]    auto_sync;
  logic [FW-1:0] frame_cnt;

  assign auto_req = (state == IDLE) && auto_sync[1] && frame &&
                    (frame_cnt == FW'(AUTO_FRAMES - 1));

  always_ff @(posedge CLK or negedge init) begin
    if (!init) begin
      auto_sync <= '0;
      frame_cnt <= '0;
    end else begin
      auto_sync <= {auto_sync[0], auto_mode};
      if (manual_req || !auto_sync[1] || state != IDLE)
        frame_cnt <= '0;
      else if (frame)
        frame_cnt <= auto_req ? '0 : frame_cnt + FW'(1);
    end
  end
`else
  logic auto_unused;
  assign auto_unused = auto_mode;
  assign auto_req    = 1'b0;
`endif

  // Simultaneous next and prev cancel each other
  assign step_next = btn_rise[0] | auto_req;
  assign step_prev = btn_rise[1];
  assign accept    = step_next ^ step_prev;

  always_comb begin
    t_step = target;
    if (step_next)
      t_step = (target == 3'(NUM_IMAGES - 1)) ? 3'd0 : target + 3'd1;
    else if (step_prev)
      t_step = (target == 3'd0) ? 3'(NUM_IMAGES - 1) : target - 3'd1;
  end

  always_ff @(posedge CLK or negedge init) begin
    if (!init) begin
      state   <= IDLE;
      target  <= '0;
      num     <= '0;
      pending <= 1'b0;
    end else begin
      if (accept) target <= t_step;
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= WAIT_FRAME;
            pending <= 1'b1;
          end
        end
        WAIT_FRAME: begin
          // A request landing on the boundary is folded into this commit
          if (frame) begin
            num     <= accept ? t_step : target;
            state   <= IDLE;
            pending <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_image_sequencer.sv
// Randomized self-checking bench for image_sequencer against an index-arithmetic model.
module tb_image_sequencer;
  localparam int N  = 3;
  localparam int DB = 4;
  localparam int AF = 2;

  logic       CLK = 1'b0;
  logic       init, btn_next, btn_prev, auto_mode, V_sync;
  logic [2:0] num;
  logic       pending;

  int n_cmp = 0;
  int n_err = 0;
  int m_num = 0;

  always #5 CLK = ~CLK;

  image_sequencer #(.NUM_IMAGES(N), .DEBOUNCE_CYCLES(DB), .AUTO_FRAMES(AF)) dut (
    .CLK(CLK), .init(init), .btn_next(btn_next), .btn_prev(btn_prev),
    .auto_mode(auto_mode), .V_sync(V_sync), .num(num), .pending(pending)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic press(input bit nxt);
    if (nxt) btn_next = 1'b1; else btn_prev = 1'b1;
    cyc(10);
    btn_next = 1'b0; btn_prev = 1'b0;
    cyc(10);
  endtask

  task automatic vsync_pulse();
    V_sync = 1'b0;
    cyc(3);
    V_sync = 1'b1;
    cyc(3);
  endtask

  task automatic test_reset();
    init = 1'b0; btn_next = 0; btn_prev = 0; auto_mode = 0; V_sync = 1;
    cyc(3);
    n_cmp++; if (num !== 3'd0) begin n_err++; $display("FAIL reset_num got=%0d exp=0", num); end
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL reset_pending got=%0b exp=0", pending); end
    init = 1'b1;
    cyc(5);
    m_num = 0;
  endtask

  task automatic test_basic_commit();
    press(1'b1);
    n_cmp++; if (pending !== 1'b1) begin n_err++; $display("FAIL basic_pending got=%0b exp=1", pending); end
    V_sync = 1'b0;
    cyc(2);
    n_cmp++; if (num !== 3'(m_num)) begin n_err++; $display("FAIL basic_early got=%0d exp=%0d", num, m_num); end
    m_num = (m_num + 1) % N;
    cyc(1);
    n_cmp++; if (num !== 3'(m_num)) begin n_err++; $display("FAIL basic_commit got=%0d exp=%0d", num, m_num); end
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL basic_clear got=%0b exp=0", pending); end
    V_sync = 1'b1;
    cyc(3);
  endtask

  task automatic test_bounce();
    repeat (5) begin
      btn_next = 1'b1; cyc(2);
      btn_next = 1'b0; cyc(3);
    end
    cyc(8);
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL bounce_pending got=%0b exp=0", pending); end
    vsync_pulse();
    n_cmp++; if (num !== 3'(m_num)) begin n_err++; $display("FAIL bounce_num got=%0d exp=%0d", num, m_num); end
  endtask

  task automatic test_accumulate();
    for (int i = 0; i < N; i++) press(1'b1);
    n_cmp++; if (pending !== 1'b1) begin n_err++; $display("FAIL accum_pending got=%0b exp=1", pending); end
    vsync_pulse();
    n_cmp++; if (num !== 3'(m_num)) begin n_err++; $display("FAIL accum_num got=%0d exp=%0d", num, m_num); end
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL accum_clear got=%0b exp=0", pending); end
  endtask

  task automatic test_wrap_and_both();
    while (m_num != 0) begin
      press(1'b1); vsync_pulse();
      m_num = (m_num + 1) % N;
    end
    press(1'b0);
    vsync_pulse();
    m_num = N - 1;
    n_cmp++; if (num !== 3'(m_num)) begin n_err++; $display("FAIL prev_wrap got=%0d exp=%0d", num, m_num); end
    btn_next = 1'b1; btn_prev = 1'b1;
    cyc(10);
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL both_pending got=%0b exp=0", pending); end
    btn_next = 1'b0; btn_prev = 1'b0;
    cyc(10);
    vsync_pulse();
    n_cmp++; if (num !== 3'(m_num)) begin n_err++; $display("FAIL both_num got=%0d exp=%0d", num, m_num); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int k, tgt;
      k = $urandom_range(0, 4);
      tgt = m_num;
      for (int j = 0; j < k; j++) begin
        bit nx;
        nx = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) begin
          btn_prev = 1'b1; cyc(2); btn_prev = 1'b0; cyc(3);
        end
        press(nx);
        tgt = nx ? (tgt + 1) % N : (tgt + N - 1) % N;
      end
      n_cmp++; if (pending !== (k > 0)) begin n_err++; $display("FAIL rand_pending it=%0d got=%0b exp=%0b", it, pending, k > 0); end
      vsync_pulse();
      m_num = tgt;
      n_cmp++; if (num !== 3'(m_num)) begin n_err++; $display("FAIL rand_num it=%0d got=%0d exp=%0d", it, num, m_num); end
      n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL rand_clear it=%0d got=%0b exp=0", it, pending); end
    end
  endtask

  task automatic test_auto();
    int exp_seq[6];
    int base;
    base = m_num;
`ifdef IMG_SEQ_AUTO_EN
    exp_seq = '{base, base, (base + 1) % N, (base + 1) % N, (base + 1) % N, (base + 2) % N};
`else
    exp_seq = '{base, base, base, base, base, base};
`endif
    auto_mode = 1'b1;
    cyc(4);
    for (int p = 0; p < 6; p++) begin
      vsync_pulse();
      n_cmp++; if (num !== 3'(exp_seq[p])) begin n_err++; $display("FAIL auto_num pulse=%0d got=%0d exp=%0d", p + 1, num, exp_seq[p]); end
    end
    auto_mode = 1'b0;
    cyc(4);
    m_num = exp_seq[5];
    vsync_pulse();
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL auto_off_pending got=%0b exp=0", pending); end
  endtask

  task automatic test_reset_pending();
    press(1'b1);
    n_cmp++; if (pending !== 1'b1) begin n_err++; $display("FAIL rstp_pre got=%0b exp=1", pending); end
    #2 init = 1'b0;
    #1;
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL rstp_async got=%0b exp=0", pending); end
    cyc(2);
    init = 1'b1;
    cyc(2);
    m_num = 0;
    vsync_pulse();
    n_cmp++; if (num !== 3'd0) begin n_err++; $display("FAIL rstp_num got=%0d exp=0", num); end
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL rstp_pending got=%0b exp=0", pending); end
  endtask

  task automatic test_held_through_reset();
    btn_next = 1'b1;
    cyc(10);
    init = 1'b0;
    cyc(2);
    init = 1'b1;
    m_num = 0;
    cyc(10);
    n_cmp++; if (pending !== 1'b1) begin n_err++; $display("FAIL held_pending got=%0b exp=1", pending); end
    btn_next = 1'b0;
    cyc(10);
    vsync_pulse();
    m_num = 1;
    n_cmp++; if (num !== 3'(m_num)) begin n_err++; $display("FAIL held_num got=%0d exp=%0d", num, m_num); end
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_bounce();
    test_accumulate();
    test_wrap_and_both();
    test_random();
    test_auto();
    test_reset_pending();
    test_held_through_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
